// File: rtl/rvfi_imem_arbiter.sv
// rvfi_imem_arbiter
// Shares one single-port, word-wide memory between an instruction-fetch port
// (port 0) and a data/debug read port (port 1). Arbitration is round-robin
// with a single outstanding transaction. Port 0 read data gets the imem
// halfword overlay so fetched instructions agree with the formal harness's
// imem_addr/imem_data pair. A wait-cycle watchdog aborts a memory that never
// answers and reports it as an error response plus a sticky timeout flag.
module rvfi_imem_arbiter #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_addr,
    output logic            rsp0_valid,
    output logic [31:0]     rsp0_data,
    output logic            rsp0_err,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_addr,
    output logic            rsp1_valid,
    output logic [31:0]     rsp1_data,
    output logic            rsp1_err,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rvalid,
    input  logic [31:0]     mem_rdata,
    input  logic [XLEN-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic            busy,
    output logic            timeout
);

    // Counter is at least one bit wide so MAX_WAIT = 0 (watchdog off) still elaborates.
    localparam int            CW         = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);
    localparam logic          WD_ENABLE  = (MAX_WAIT != 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      r_state;
    logic            r_last_grant;
    logic            r_port;
    logic            r_mem_valid;
    logic [XLEN-1:0] r_mem_addr;
    logic [CW-1:0]   r_wait_cnt;
    logic            r_rsp0_valid;
    logic [31:0]     r_rsp0_data;
    logic            r_rsp0_err;
    logic            r_rsp1_valid;
    logic [31:0]     r_rsp1_data;
    logic            r_rsp1_err;
    logic            r_timeout;

    logic [1:0]      w_next_state;
    logic            w_grant;
    logic            w_idle;
    logic            w_accept0;
    logic            w_accept1;
    logic            w_accept;
    logic            w_done;
    logic            w_expire;
    logic [XLEN-1:0] w_req_addr;
    logic [XLEN-1:0] w_word_addr;
    logic [31:0]     w_rdata0;
    logic            w_unused_bits;

    // Replace the halfword selected by ov_addr[1] when ov_addr lies in the word being read.
    function automatic logic [31:0] f_overlay(
        input logic [31:0]     rdata,
        input logic [XLEN-1:0] word_addr,
        input logic [XLEN-1:0] ov_addr,
        input logic [15:0]     ov_data
    );
        logic [31:0] v_data;
        v_data = rdata;
        if ({ov_addr[XLEN-1:2], 2'b00} == word_addr) begin
            if (ov_addr[1]) begin
                v_data[31:16] = ov_data;
            end else begin
                v_data[15:0] = ov_data;
            end
        end else begin
            v_data = rdata;
        end
        return v_data;
    endfunction

    assign w_idle      = (r_state == S_IDLE);
    assign w_accept0   = w_idle && req0_valid && (w_grant == 1'b0);
    assign w_accept1   = w_idle && req1_valid && (w_grant == 1'b1);
    assign w_accept    = w_accept0 || w_accept1;
    assign w_req_addr  = w_accept1 ? req1_addr : req0_addr;
    assign w_word_addr = {w_req_addr[XLEN-1:2], 2'b00};
    assign w_done      = (r_state == S_RESP) && mem_rvalid;
    assign w_expire    = WD_ENABLE && !w_idle && (r_wait_cnt == WAIT_LIMIT) && !w_done;
    assign w_rdata0    = f_overlay(mem_rdata, r_mem_addr, imem_addr, imem_data);

    // Byte-offset bits of request addresses never reach the word-wide memory.
    assign w_unused_bits = ^{w_req_addr[1:0], imem_addr[0]};

    // Round-robin pick: a lone requester wins, a tie goes to the port not granted last.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end else begin
            w_grant = 1'b0;
        end
    end

    // Transaction sequencing: accept in IDLE, address phase in REQ, data phase in RESP.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_REQ;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_REQ: begin
                if (w_expire) begin
                    w_next_state = S_IDLE;
                end else if (mem_ready) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_REQ;
                end
            end
            S_RESP: begin
                if (w_done || w_expire) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_RESP;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Remember the accepted port and the round-robin history.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
        end else if (w_accept) begin
            r_last_grant <= w_accept1;
            r_port       <= w_accept1;
        end else begin
            r_last_grant <= r_last_grant;
            r_port       <= r_port;
        end
    end

    // Memory request side: valid for the whole REQ phase, address held stable.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mem_valid <= 1'b0;
            r_mem_addr  <= {XLEN{1'b0}};
        end else begin
            r_mem_valid <= (w_next_state == S_REQ);
            if (w_accept) begin
                r_mem_addr <= w_word_addr;
            end else begin
                r_mem_addr <= r_mem_addr;
            end
        end
    end

    // Watchdog: cycles spent in REQ+RESP, zeroed whenever the arbiter is or goes idle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wait_cnt <= {CW{1'b0}};
        end else if (w_idle || (w_next_state == S_IDLE)) begin
            r_wait_cnt <= {CW{1'b0}};
        end else begin
            r_wait_cnt <= r_wait_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Registered response pulses; data holds between pulses, error responses carry zero data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rsp0_valid <= 1'b0;
            r_rsp0_data  <= 32'h0000_0000;
            r_rsp0_err   <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_data  <= 32'h0000_0000;
            r_rsp1_err   <= 1'b0;
        end else begin
            r_rsp0_valid <= (w_done || w_expire) && (r_port == 1'b0);
            r_rsp1_valid <= (w_done || w_expire) && (r_port == 1'b1);
            r_rsp0_err   <= w_expire && (r_port == 1'b0);
            r_rsp1_err   <= w_expire && (r_port == 1'b1);
            if (w_done && (r_port == 1'b0)) begin
                r_rsp0_data <= w_rdata0;
            end else if (w_expire && (r_port == 1'b0)) begin
                r_rsp0_data <= 32'h0000_0000;
            end else begin
                r_rsp0_data <= r_rsp0_data;
            end
            if (w_done && (r_port == 1'b1)) begin
                r_rsp1_data <= mem_rdata;
            end else if (w_expire && (r_port == 1'b1)) begin
                r_rsp1_data <= 32'h0000_0000;
            end else begin
                r_rsp1_data <= r_rsp1_data;
            end
        end
    end

    // Sticky record that the watchdog has ever fired.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_timeout <= 1'b0;
        end else if (w_expire) begin
            r_timeout <= 1'b1;
        end else begin
            r_timeout <= r_timeout;
        end
    end

    assign req0_ready = w_accept0;
    assign req1_ready = w_accept1;
    assign mem_valid  = r_mem_valid;
    assign mem_addr   = r_mem_addr;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp0_data  = r_rsp0_data;
    assign rsp0_err   = r_rsp0_err;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp1_data  = r_rsp1_data;
    assign rsp1_err   = r_rsp1_err;
    assign busy       = !w_idle;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_rvfi_imem_arbiter.sv
// Directed bench for rvfi_imem_arbiter: a transaction-level model checked
// against the DUT every cycle, plus hand-computed literal expectations.
module tb_rvfi_imem_arbiter;
    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_err;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_err;
    logic [31:0] req0_addr, req1_addr, rsp0_data, rsp1_data;
    logic        mem_valid, mem_ready, mem_rvalid, busy, timeout;
    logic [31:0] mem_addr, mem_rdata, imem_addr;
    logic [15:0] imem_data;

    int n_checks = 0;
    int n_fail   = 0;

    rvfi_imem_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    logic        auto_en = 1'b1;
    logic        man_ready = 1'b1, man_rvalid = 1'b0;
    logic [31:0] man_rdata = 32'h0;
    logic        a_ready = 1'b1, a_rvalid = 1'b0;
    logic [31:0] a_rdata = 32'h0;
    int          stall_len = 0;
    logic        mem_hang = 1'b0;
    logic        mem_fixed = 1'b1;

    assign mem_ready  = auto_en ? a_ready  : man_ready;
    assign mem_rvalid = auto_en ? a_rvalid : man_rvalid;
    assign mem_rdata  = auto_en ? a_rdata  : man_rdata;

    initial begin
        logic        hs;
        logic [31:0] hs_addr;
        int          stall_cnt;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            hs      = mem_valid && mem_ready;
            hs_addr = mem_addr;
            if (!mem_valid) stall_cnt = 0;
            else if (!mem_ready) stall_cnt++;
            @(posedge clk);
            #1;
            a_ready  = !mem_hang && (stall_cnt >= stall_len);
            a_rvalid = hs;
            if (hs) a_rdata = mem_fixed ? 32'hAAAABBBB : (hs_addr ^ 32'h5A5A0000);
        end
    end

    // ---------------- transaction-level model ----------------
    logic        m_live = 1'b0, m_active = 1'b0, m_sent = 1'b0, m_port = 1'b0;
    logic        m_last = 1'b1, m_timeout = 1'b0;
    int          m_age = 0;
    logic [31:0] m_word = 32'h0, e_mem_addr = 32'h0;
    logic        e_rv0 = 1'b0, e_rv1 = 1'b0, e_re0 = 1'b0, e_re1 = 1'b0;
    logic [31:0] e_rd0 = 32'h0, e_rd1 = 32'h0;

    function automatic logic [31:0] model_overlay(input logic [31:0] raw, input logic [31:0] word,
                                                  input logic [31:0] ia, input logic [15:0] id);
        int          sh;
        logic [31:0] mask;
        if ((ia >> 2) != (word >> 2)) return raw;
        sh   = ia[1] ? 16 : 0;
        mask = 32'h0000FFFF << sh;
        return (raw & ~mask) | ({16'h0000, id} << sh);
    endfunction

    function automatic logic model_ready(input int n);
        logic mine, other;
        mine  = (n == 0) ? req0_valid : req1_valid;
        other = (n == 0) ? req1_valid : req0_valid;
        return m_live && !m_active && mine && (!other || (m_last != n[0]));
    endfunction

    task automatic model_step();
        logic complete, expire, take0, take1;
        e_rv0 = 1'b0; e_rv1 = 1'b0; e_re0 = 1'b0; e_re1 = 1'b0;
        if (!resetn) begin
            m_live = 1'b1; m_active = 1'b0; m_sent = 1'b0; m_age = 0; m_last = 1'b1;
            m_timeout = 1'b0; e_mem_addr = 32'h0; e_rd0 = 32'h0; e_rd1 = 32'h0;
        end else if (m_active) begin
            complete = m_sent && mem_rvalid;
            expire   = (MAX_WAIT != 0) && (m_age == MAX_WAIT) && !complete;
            if (complete) begin
                if (!m_port) begin e_rv0 = 1'b1; e_rd0 = model_overlay(mem_rdata, m_word, imem_addr, imem_data); end
                else         begin e_rv1 = 1'b1; e_rd1 = mem_rdata; end
                m_active = 1'b0;
            end else if (expire) begin
                if (!m_port) begin e_rv0 = 1'b1; e_re0 = 1'b1; e_rd0 = 32'h0; end
                else         begin e_rv1 = 1'b1; e_re1 = 1'b1; e_rd1 = 32'h0; end
                m_timeout = 1'b1;
                m_active  = 1'b0;
            end else begin
                if (!m_sent && mem_ready) m_sent = 1'b1;
                m_age++;
            end
        end else begin
            take0 = model_ready(0);
            take1 = model_ready(1);
            if (take0 || take1) begin
                m_active   = 1'b1;
                m_port     = take1;
                m_word     = (take1 ? req1_addr : req0_addr) & ~32'd3;
                e_mem_addr = m_word;
                m_sent     = 1'b0;
                m_age      = 0;
                m_last     = take1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            chk("req0_ready", req0_ready, model_ready(0));
            chk("req1_ready", req1_ready, model_ready(1));
            chk("ready_exclusive", req0_ready & req1_ready, 32'd0);
            chk("mem_valid", mem_valid, m_active && !m_sent);
            chk("mem_addr", mem_addr, e_mem_addr);
            chk("busy", busy, m_active);
            chk("timeout", timeout, m_timeout);
            chk("rsp0_valid", rsp0_valid, e_rv0);
            chk("rsp0_err", rsp0_err, e_re0);
            chk("rsp0_data", rsp0_data, e_rd0);
            chk("rsp1_valid", rsp1_valid, e_rv1);
            chk("rsp1_err", rsp1_err, e_re1);
            chk("rsp1_data", rsp1_data, e_rd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        resetn = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = 32'h0; req1_addr = 32'h0; imem_addr = 32'h0; imem_data = 16'h0;
        tick(); tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("reset_busy", busy, 32'd0);
        chk("reset_mem_valid", mem_valid, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_timeout", timeout, 32'd0);
        chk("reset_rsp0_data", rsp0_data, 32'd0);

        // port 0 with overlay of the upper halfword
        imem_addr = 32'h102; imem_data = 16'h1234;
        tick(); req0_valid = 1'b1; req0_addr = 32'h100;
        @(negedge clk); chk("t1_ready0", req0_ready, 32'd1);
        tick(); req0_valid = 1'b0;
        @(negedge clk); chk("t1_mem_valid", mem_valid, 32'd1); chk("t1_mem_addr", mem_addr, 32'h100);
        tick(); @(negedge clk);
        tick(); @(negedge clk);
        chk("t1_rsp0_valid", rsp0_valid, 32'd1);
        chk("t1_rsp0_data", rsp0_data, 32'h1234BBBB);
        chk("t1_model_data", e_rd0, 32'h1234BBBB);
        chk("t1_rsp0_err", rsp0_err, 32'd0);

        // port 1: raw data, no overlay
        tick(); req1_valid = 1'b1; req1_addr = 32'h102;
        @(negedge clk); chk("t2_ready1", req1_ready, 32'd1); chk("t2_ready0", req0_ready, 32'd0);
        tick(); req1_valid = 1'b0;
        @(negedge clk); chk("t2_mem_addr", mem_addr, 32'h100);
        tick(); tick(); @(negedge clk);
        chk("t2_rsp1_valid", rsp1_valid, 32'd1);
        chk("t2_rsp1_data", rsp1_data, 32'hAAAABBBB);
        chk("t2_rsp0_hold", rsp0_data, 32'h1234BBBB);

        // both ports always requesting: alternate grants, back-to-back
        mem_fixed = 1'b0; imem_addr = 32'h300; imem_data = 16'hBEEF;
        tick(); tick();
        tick(); req0_valid = 1'b1; req0_addr = 32'h300; req1_valid = 1'b1; req1_addr = 32'h404;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_grant0", req0_ready, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("t3_grant1", req1_ready, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k == 1 || k == 3) chk("t3_rsp0_data", rsp0_data, 32'h5A5ABEEF);
            if (k == 2)           chk("t3_rsp1_data", rsp1_data, 32'h5A5A0404);
            if (k < 3) begin tick(); tick(); tick(); end
        end
        tick(); req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick(); @(negedge clk);
        chk("t3_last_rsp1_valid", rsp1_valid, 32'd1);
        chk("t3_last_rsp1_data", rsp1_data, 32'h5A5A0404);

        // memory stalls mem_ready for three cycles
        tick(); stall_len = 3;
        tick();
        tick(); req0_valid = 1'b1; req0_addr = 32'h200;
        @(negedge clk); chk("t4_ready0", req0_ready, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick(); req0_valid = 1'b0;
            @(negedge clk);
            chk("t4_mem_valid", mem_valid, 32'd1);
            chk("t4_mem_addr", mem_addr, 32'h200);
            chk("t4_busy", busy, 32'd1);
        end
        tick(); stall_len = 0;
        @(negedge clk); chk("t4_resp_mem_valid", mem_valid, 32'd0); chk("t4_resp_busy", busy, 32'd1);
        tick(); @(negedge clk);
        chk("t4_rsp0_valid", rsp0_valid, 32'd1);
        chk("t4_rsp0_data", rsp0_data, 32'h5A5A0200);

        // watchdog expiry with mem_ready stuck low
        tick(); mem_hang = 1'b1;
        tick();
        tick(); req0_valid = 1'b1; req0_addr = 32'h240;
        @(negedge clk); chk("t5_ready0", req0_ready, 32'd1);
        tick(); req0_valid = 1'b0;
        repeat (15) tick();
        @(negedge clk);
        chk("t5_pre_mem_valid", mem_valid, 32'd1);
        chk("t5_pre_timeout", timeout, 32'd0);
        tick(); @(negedge clk);
        chk("t5_rsp0_valid", rsp0_valid, 32'd1);
        chk("t5_rsp0_err", rsp0_err, 32'd1);
        chk("t5_rsp0_data", rsp0_data, 32'd0);
        chk("t5_timeout", timeout, 32'd1);
        chk("t5_busy", busy, 32'd0);
        tick(); mem_hang = 1'b0;
        tick(); tick();
        tick(); req1_valid = 1'b1; req1_addr = 32'h500;
        @(negedge clk); chk("t5_ready1", req1_ready, 32'd1);
        tick(); req1_valid = 1'b0;
        tick(); tick(); @(negedge clk);
        chk("t5_good_rsp1", rsp1_data, 32'h5A5A0500);
        chk("t5_good_err", rsp1_err, 32'd0);
        chk("t5_timeout_sticky", timeout, 32'd1);

        // reset during RESP, late mem_rvalid ignored
        tick(); man_ready = 1'b1; man_rvalid = 1'b0; auto_en = 1'b0;
        tick(); req0_valid = 1'b1; req0_addr = 32'h180;
        @(negedge clk); chk("t6_ready0", req0_ready, 32'd1);
        tick(); req0_valid = 1'b0;
        @(negedge clk); chk("t6_mem_addr", mem_addr, 32'h180);
        tick(); resetn = 1'b0; man_ready = 1'b0;
        @(negedge clk); chk("t6_in_resp_busy", busy, 32'd1);
        tick(); resetn = 1'b1; man_rvalid = 1'b1; man_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t6_after_reset_mem_valid", mem_valid, 32'd0);
        chk("t6_after_reset_busy", busy, 32'd0);
        chk("t6_after_reset_timeout", timeout, 32'd0);
        tick(); man_rvalid = 1'b0;
        @(negedge clk);
        chk("t6_no_rsp0", rsp0_valid, 32'd0);
        chk("t6_no_rsp1", rsp1_valid, 32'd0);

        // stray mem_rvalid during REQ must not complete the transaction
        tick(); req1_valid = 1'b1; req1_addr = 32'h108;
        @(negedge clk); chk("t7_ready1", req1_ready, 32'd1);
        tick(); req1_valid = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h99999999;
        @(negedge clk); chk("t7_mem_valid", mem_valid, 32'd1);
        tick(); man_ready = 1'b1; man_rvalid = 1'b0;
        @(negedge clk); chk("t7_mem_valid_hold", mem_valid, 32'd1);
        tick(); man_ready = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h11112222;
        @(negedge clk); chk("t7_no_early_rsp", rsp1_valid, 32'd0);
        tick(); man_rvalid = 1'b0;
        @(negedge clk);
        chk("t7_rsp1_valid", rsp1_valid, 32'd1);
        chk("t7_rsp1_data", rsp1_data, 32'h11112222);

        // normal transaction after reset, overlay of the upper halfword
        tick(); auto_en = 1'b1; imem_addr = 32'h106; imem_data = 16'hCAFE;
        tick();
        tick(); req0_valid = 1'b1; req0_addr = 32'h104;
        @(negedge clk); chk("t8_ready0", req0_ready, 32'd1);
        tick(); req0_valid = 1'b0;
        tick(); tick(); @(negedge clk);
        chk("t8_rsp0_valid", rsp0_valid, 32'd1);
        chk("t8_rsp0_data", rsp0_data, 32'hCAFE0104);

        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
